axi4_lite_register_file: RTL and testbench

AXI4-Lite subordinate (responder) that terminates an `axi4_if` bus in a bank of R software-visible registers. It is the endpoint that sits on the manager-side output of our AXI4-Lite clock-domain crossing and interconnect blocks, so IP can expose control/status registers without its own bus logic. It runs on one clock, uses independent read and write state machines, and supports byte strobes, out-of-range error responses and per-register write pulses.

---
 rtl/axi4_lite_register_file.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_axi4_lite_register_file.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_register_file.sv
// -----------------------------------------------------------------------------
// axi4_lite_register_file
//
// AXI4-Lite subordinate that terminates a bus in a bank of R software-visible
// registers. Read and write channels are served by two independent state
// machines, each allowing one outstanding transaction. Byte strobes, an
// out-of-range SLVERR response and per-register write pulses are supported.
//
// Parameters
//   A : address width in bits
//   N : data width in bytes (4 or 8)
//   R : number of registers (power of two, >= 2)
//
// Ports
//   i_aclk, i_aresetn           : clock, asynchronous active-low reset
//   i_awvalid/o_awready/i_awaddr: write address channel
//   i_wvalid/o_wready/i_wdata/i_wstrb : write data channel
//   o_bvalid/i_bready/o_bresp   : write response channel
//   i_arvalid/o_arready/i_araddr: read address channel
//   o_rvalid/i_rready/o_rdata/o_rresp : read data channel
//   o_reg_q                     : register k at bits [k*8N +: 8N]
//   o_reg_wr                    : one-cycle pulse when register k is written
// -----------------------------------------------------------------------------
module axi4_lite_register_file #(
  parameter int A = 32,
  parameter int N = 4,
  parameter int R = 16
) (
  input  logic               i_aclk,
  input  logic               i_aresetn,
  // write address
  input  logic               i_awvalid,
  output logic               o_awready,
  input  logic [A-1:0]       i_awaddr,
  // write data
  input  logic               i_wvalid,
  output logic               o_wready,
  input  logic [8*N-1:0]     i_wdata,
  input  logic [N-1:0]       i_wstrb,
  // write response
  output logic               o_bvalid,
  input  logic               i_bready,
  output logic [1:0]         o_bresp,
  // read address
  input  logic               i_arvalid,
  output logic               o_arready,
  input  logic [A-1:0]       i_araddr,
  // read data
  output logic               o_rvalid,
  input  logic               i_rready,
  output logic [8*N-1:0]     o_rdata,
  output logic [1:0]         o_rresp,
  // register bank
  output logic [R*8*N-1:0]   o_reg_q,
  output logic [R-1:0]       o_reg_wr
);

  localparam int NB = $clog2(N);   // byte-offset bits inside a word
  localparam int RB = $clog2(R);   // word-index bits
  localparam int HB = NB + RB;     // first address bit that must be zero
  localparam int DW = 8 * N;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_W    = 2'd2,
    W_RESP = 2'd3
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_t;

  // Address lies inside the register window when every bit above it is zero.
  function automatic logic addr_in_range(input logic [A-1:0] addr);
    return (addr[A-1:HB] == {(A-HB){1'b0}});
  endfunction

  function automatic logic [RB-1:0] addr_index(input logic [A-1:0] addr);
    return addr[NB +: RB];
  endfunction

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_regs [R];
  logic [R-1:0]  r_reg_wr;

  wstate_t       r_wstate;
  logic          r_awready;
  logic          r_wready;
  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic [A-1:0]  r_awaddr;
  logic [DW-1:0] r_wdata;
  logic [N-1:0]  r_wstrb;

  rstate_t       r_rstate;
  logic          r_arready;
  logic          r_rvalid;
  logic [1:0]    r_rresp;
  logic [DW-1:0] r_rdata;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  wstate_t       w_wstate_nxt;
  rstate_t       w_rstate_nxt;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_ar_hs;
  logic          w_commit;
  logic [A-1:0]  w_cmt_addr;
  logic [DW-1:0] w_cmt_data;
  logic [N-1:0]  w_cmt_strb;
  logic          w_cmt_in_range;
  logic [RB-1:0] w_cmt_idx;
  logic          w_ar_in_range;
  logic [RB-1:0] w_ar_idx;
  logic          w_unused;

  assign w_aw_hs = i_awvalid & r_awready;
  assign w_w_hs  = i_wvalid  & r_wready;
  assign w_ar_hs = i_arvalid & r_arready;

  assign w_cmt_in_range = addr_in_range(w_cmt_addr);
  assign w_cmt_idx      = addr_index(w_cmt_addr);
  assign w_ar_in_range  = addr_in_range(i_araddr);
  assign w_ar_idx       = addr_index(i_araddr);

  // Byte-offset address bits carry no meaning for word-wide registers.
  assign w_unused = ^{i_awaddr[NB-1:0], i_araddr[NB-1:0]};

  // Write next-state and commit selection: the commit uses whichever half of
  // the transaction arrives live this cycle plus the half already held.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    w_cmt_addr   = r_awaddr;
    w_cmt_data   = r_wdata;
    w_cmt_strb   = r_wstrb;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wstate_nxt = W_RESP;
          w_commit     = 1'b1;
          w_cmt_addr   = i_awaddr;
          w_cmt_data   = i_wdata;
          w_cmt_strb   = i_wstrb;
        end else if (w_aw_hs) begin
          w_wstate_nxt = W_AW;
        end else if (w_w_hs) begin
          w_wstate_nxt = W_W;
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_AW: begin
        if (w_w_hs) begin
          w_wstate_nxt = W_RESP;
          w_commit     = 1'b1;
          w_cmt_data   = i_wdata;
          w_cmt_strb   = i_wstrb;
        end else begin
          w_wstate_nxt = W_AW;
        end
      end
      W_W: begin
        if (w_aw_hs) begin
          w_wstate_nxt = W_RESP;
          w_commit     = 1'b1;
          w_cmt_addr   = i_awaddr;
        end else begin
          w_wstate_nxt = W_W;
        end
      end
      W_RESP: begin
        if (i_bready) begin
          w_wstate_nxt = W_IDLE;
        end else begin
          w_wstate_nxt = W_RESP;
        end
      end
      default: begin
        w_wstate_nxt = W_IDLE;
      end
    endcase
  end

  // Write channel state, registered readys/response and held address/data.
  // Readys are flops fed from the next state so they are low during reset and
  // rise one edge after reset release.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awaddr  <= {A{1'b0}};
      r_wdata   <= {DW{1'b0}};
      r_wstrb   <= {N{1'b0}};
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_W);
      r_wready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_AW);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_aw_hs) begin
        r_awaddr <= i_awaddr;
      end
      if (w_w_hs) begin
        r_wdata <= i_wdata;
        r_wstrb <= i_wstrb;
      end
      if (w_commit) begin
        r_bresp <= w_cmt_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Register bank update and write pulse, both on the edge entering W_RESP.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      for (int k = 0; k < R; k++) begin
        r_regs[k] <= {DW{1'b0}};
      end
      r_reg_wr <= {R{1'b0}};
    end else begin
      r_reg_wr <= {R{1'b0}};
      if (w_commit && w_cmt_in_range) begin
        for (int k = 0; k < R; k++) begin
          if (w_cmt_idx == RB'(k)) begin
            for (int b = 0; b < N; b++) begin
              if (w_cmt_strb[b]) begin
                r_regs[k][b*8 +: 8] <= w_cmt_data[b*8 +: 8];
              end
            end
            r_reg_wr[k] <= |w_cmt_strb;
          end
        end
      end
    end
  end

  // Read next-state logic.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rstate_nxt = R_RESP;
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_RESP: begin
        if (i_rready) begin
          w_rstate_nxt = R_IDLE;
        end else begin
          w_rstate_nxt = R_RESP;
        end
      end
      default: begin
        w_rstate_nxt = R_IDLE;
      end
    endcase
  end

  // Read channel state and response capture. rdata samples the bank before
  // any same-edge write lands, so a colliding read sees the old value.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= {DW{1'b0}};
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_RESP);
      if (w_ar_hs) begin
        if (w_ar_in_range) begin
          r_rdata <= r_regs[w_ar_idx];
          r_rresp <= RESP_OKAY;
        end else begin
          r_rdata <= {DW{1'b0}};
          r_rresp <= RESP_SLVERR;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;
  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rresp   = r_rresp;
  assign o_rdata   = r_rdata;
  assign o_reg_wr  = r_reg_wr;

  for (genvar k = 0; k < R; k++) begin : g_reg_q
    assign o_reg_q[k*DW +: DW] = r_regs[k];
  end

endmodule

// File: tb/tb_axi4_lite_register_file.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_register_file
//
// Directed bench: a table of single-beat write/read vectors with hand-computed
// results, followed by hand-written sequences for split ordering, read/write
// collision, backpressure and reset in the middle of a transaction.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_axi4_lite_register_file;

  localparam int A  = 32;
  localparam int N  = 4;
  localparam int R  = 16;
  localparam int DW = 32;
  localparam int QW = R * DW;

  logic            clk;
  logic            aresetn;
  logic            awvalid, awready;
  logic [A-1:0]    awaddr;
  logic            wvalid, wready;
  logic [DW-1:0]   wdata;
  logic [N-1:0]    wstrb;
  logic            bvalid, bready;
  logic [1:0]      bresp;
  logic            arvalid, arready;
  logic [A-1:0]    araddr;
  logic            rvalid, rready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic [QW-1:0]   reg_q;
  logic [R-1:0]    reg_wr;

  axi4_lite_register_file #(.A(A), .N(N), .R(R)) dut (
    .i_aclk    (clk),
    .i_aresetn (aresetn),
    .i_awvalid (awvalid),
    .o_awready (awready),
    .i_awaddr  (awaddr),
    .i_wvalid  (wvalid),
    .o_wready  (wready),
    .i_wdata   (wdata),
    .i_wstrb   (wstrb),
    .o_bvalid  (bvalid),
    .i_bready  (bready),
    .o_bresp   (bresp),
    .i_arvalid (arvalid),
    .o_arready (arready),
    .i_araddr  (araddr),
    .o_rvalid  (rvalid),
    .i_rready  (rready),
    .o_rdata   (rdata),
    .o_rresp   (rresp),
    .o_reg_q   (reg_q),
    .o_reg_wr  (reg_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [R];

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_val;   // register value after a write, rdata for a read
  } vec_t;

  vec_t vecs [14];

  function automatic logic [QW-1:0] mdl_flat();
    logic [QW-1:0] f;
    for (int k = 0; k < R; k++) begin
      f[k*DW +: DW] = mdl[k];
    end
    return f;
  endfunction

  task automatic chk(input string nm, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp_resp, input logic [31:0] exp_val);
    logic [R-1:0] exp_wr;
    logic         in_rng;
    int           idx;
    idx    = int'(a[5:2]);
    in_rng = (exp_resp == 2'b00);
    exp_wr = (in_rng && (s != 4'h0)) ? (R'(1) << idx) : {R{1'b0}};
    @(negedge clk);
    chk("wr_ready_idle", QW'({awready, wready}), QW'(2'b11));
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", QW'(bvalid), QW'(1'b1));
    chk("wr_bresp", QW'(bresp), QW'(exp_resp));
    chk("wr_reg_wr", QW'(reg_wr), QW'(exp_wr));
    chk("wr_ready_busy", QW'({awready, wready}), QW'(2'b00));
    if (in_rng) begin
      mdl[idx] = exp_val;
    end
    chk("wr_reg_q", reg_q, mdl_flat());
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("wr_bvalid_clear", QW'(bvalid), QW'(1'b0));
    chk("wr_reg_wr_clear", QW'(reg_wr), QW'(0));
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] exp_resp, input logic [31:0] exp_data);
    @(negedge clk);
    chk("rd_arready_idle", QW'(arready), QW'(1'b1));
    arvalid = 1'b1; araddr = a;
    @(negedge clk);
    arvalid = 1'b0;
    chk("rd_rvalid", QW'(rvalid), QW'(1'b1));
    chk("rd_rdata", QW'(rdata), QW'(exp_data));
    chk("rd_rresp", QW'(rresp), QW'(exp_resp));
    chk("rd_arready_busy", QW'(arready), QW'(1'b0));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rd_rvalid_clear", QW'(rvalid), QW'(1'b0));
  endtask

  initial begin
    // vector table: is_wr, addr, data, strb, exp_resp, exp_val
    vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'h0, 2'b00, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'hAABB_CCDD, 4'hF, 2'b00, 32'hAABB_CCDD};
    vecs[3]  = '{1'b1, 32'h0000_003C, 32'h1234_5678, 4'hF, 2'b00, 32'h1234_5678};
    vecs[4]  = '{1'b0, 32'h0000_003F, 32'h0000_0000, 4'h0, 2'b00, 32'h1234_5678};
    vecs[5]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0000_0000};
    vecs[6]  = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 2'b10, 32'h0000_0000};
    vecs[7]  = '{1'b1, 32'h0000_0010, 32'h0000_0055, 4'h0, 2'b00, 32'h0000_0000};
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 2'b00, 32'h0000_0000};
    vecs[9]  = '{1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'hC, 2'b00, 32'hCAFE_0000};
    vecs[10] = '{1'b0, 32'h0000_0016, 32'h0000_0000, 4'h0, 2'b00, 32'hCAFE_0000};
    vecs[11] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0000_0000};
    vecs[12] = '{1'b1, 32'h0000_0004, 32'h0000_0001, 4'hF, 2'b00, 32'h0000_0001};
    vecs[13] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 2'b00, 32'hAABB_CCDD};

    for (int k = 0; k < R; k++) mdl[k] = 32'h0;
    aresetn = 1'b0;
    awvalid = 1'b0; awaddr = 32'h0; wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
    bready = 1'b0; arvalid = 1'b0; araddr = 32'h0; rready = 1'b0;

    // ---- reset with random valids ----
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_outputs", QW'({awready, wready, arready, bvalid, rvalid}), QW'(5'b0));
      awvalid = 1'($urandom_range(0, 1));
      wvalid  = 1'($urandom_range(0, 1));
      arvalid = 1'($urandom_range(0, 1));
      bready  = 1'($urandom_range(0, 1));
      rready  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    aresetn = 1'b1;
    #1;
    chk("rst_release_ready_low", QW'({awready, wready, arready}), QW'(3'b000));
    @(negedge clk);
    chk("rst_release_ready_high", QW'({awready, wready, arready}), QW'(3'b111));
    chk("rst_reg_q", reg_q, QW'(0));
    chk("rst_payload", QW'({reg_wr, bresp, rresp, rdata}), QW'(0));

    // ---- table-driven vectors ----
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, vecs[i].exp_val);
      end else begin
        do_read(vecs[i].addr, vecs[i].exp_resp, vecs[i].exp_val);
      end
    end

    // ---- split: W first, AW three cycles later; reg0 AABBCCDD -> AA22CC44 ----
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'h5;
    @(negedge clk);
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("split_no_bvalid", QW'(bvalid), QW'(1'b0));
      chk("split_ready_w_held", QW'({awready, wready}), QW'(2'b10));
      @(negedge clk);
    end
    awvalid = 1'b1; awaddr = 32'h0;
    @(negedge clk);
    awvalid = 1'b0;
    mdl[0] = 32'hAA22_CC44;
    chk("split_bvalid", QW'(bvalid), QW'(1'b1));
    chk("split_bresp", QW'(bresp), QW'(2'b00));
    chk("split_reg_wr", QW'(reg_wr), QW'(16'h0001));
    chk("split_reg_q", reg_q, mdl_flat());
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("split_bvalid_clear", QW'(bvalid), QW'(1'b0));

    // ---- collision: AW 0x4 first, then W (0x5) together with AR 0x4 ----
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h4;
    @(negedge clk);
    awvalid = 1'b0;
    chk("coll_ready_aw_held", QW'({awready, wready}), QW'(2'b01));
    wvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h4;
    @(negedge clk);
    wvalid = 1'b0; arvalid = 1'b0;
    mdl[1] = 32'h5;
    chk("coll_bvalid", QW'(bvalid), QW'(1'b1));
    chk("coll_rvalid", QW'(rvalid), QW'(1'b1));
    chk("coll_rdata_old", QW'(rdata), QW'(32'h1));
    chk("coll_reg_wr", QW'(reg_wr), QW'(16'h0002));
    chk("coll_reg_q", reg_q, mdl_flat());
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    chk("coll_valid_clear", QW'({bvalid, rvalid}), QW'(2'b00));
    do_read(32'h4, 2'b00, 32'h5);

    // ---- backpressure: bready/rready low for 10 cycles ----
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h8; wvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h3C;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    mdl[2] = 32'h0BAD_F00D;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valids", QW'({bvalid, rvalid}), QW'(2'b11));
      chk("bp_payload", QW'({bresp, rresp, rdata}), QW'({2'b00, 2'b00, 32'h1234_5678}));
      chk("bp_readys_low", QW'({awready, wready, arready}), QW'(3'b000));
      @(negedge clk);
    end
    chk("bp_reg_q", reg_q, mdl_flat());
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    chk("bp_valid_clear", QW'({bvalid, rvalid}), QW'(2'b00));
    chk("bp_readys_back", QW'({awready, wready, arready}), QW'(3'b111));

    // ---- reset in the middle of a write (W_AW) and a read (R_RESP) ----
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h0; arvalid = 1'b1; araddr = 32'h8;
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    chk("mid_rvalid_before", QW'(rvalid), QW'(1'b1));
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    aresetn = 1'b0;
    #1;
    for (int k = 0; k < R; k++) mdl[k] = 32'h0;
    chk("mid_rst_outputs", QW'({awready, wready, arready, bvalid, rvalid}), QW'(5'b0));
    chk("mid_rst_payload", QW'({reg_wr, bresp, rresp, rdata}), QW'(0));
    chk("mid_rst_reg_q", reg_q, mdl_flat());
    @(negedge clk);
    wvalid = 1'b0;
    aresetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_back", QW'({awready, wready, arready}), QW'(3'b111));
    chk("mid_rst_no_update", reg_q, mdl_flat());
    chk("mid_rst_no_resp", QW'({bvalid, rvalid}), QW'(2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
